// File: rtl/uivbuf_ctrl_if.sv
// rtl/uivbuf_ctrl_if.sv - frame pulses in, buffer indices out; stat counters when UIVBUF_STAT_EN
interface uivbuf_ctrl_if;
    logic        wr_fs_i;
    logic        wr_fe_i;
    logic        rd_fs_i;
    logic [7:0]  wr_bufn_o;
    logic [7:0]  rd_bufn_o;
    logic        rd_valid_o;
    logic        wr_abort_o;
`ifdef UIVBUF_STAT_EN
    logic [15:0] drop_cnt_o;
    logic [15:0] rep_cnt_o;
`endif

    // DMA side: drives frame pulses, consumes buffer numbers
    modport master (
        output wr_fs_i, wr_fe_i, rd_fs_i,
`ifdef UIVBUF_STAT_EN
        input  drop_cnt_o, rep_cnt_o,
`endif
        input  wr_bufn_o, rd_bufn_o, rd_valid_o, wr_abort_o
    );

    // Index manager side
    modport slave (
        input  wr_fs_i, wr_fe_i, rd_fs_i,
`ifdef UIVBUF_STAT_EN
        output drop_cnt_o, rep_cnt_o,
`endif
        output wr_bufn_o, rd_bufn_o, rd_valid_o, wr_abort_o
    );
endinterface

// File: rtl/uivbuf_ctrl.sv
// rtl/uivbuf_ctrl.sv - frame-buffer index manager; optional drop/repeat counters under UIVBUF_STAT_EN
module uivbuf_ctrl #(
    parameter int BUF_DELAY = 1,
    parameter int BUF_LENTH = 3,
    parameter int MODE      = 0
) (
    input  logic         ui_clk,
    input  logic         ui_rst,
    uivbuf_ctrl_if.slave bus
);
    localparam logic [8:0] L9       = 9'(BUF_LENTH);
    localparam logic [8:0] D9       = 9'(BUF_DELAY);
    localparam logic [8:0] LAST9    = 9'(BUF_LENTH - 1);
    localparam logic [7:0] RD_RST   = (MODE == 0 && BUF_DELAY > 0) ? 8'(BUF_LENTH - BUF_DELAY) : 8'd0;
    // MODE 0 needs BUF_DELAY completions before the lagged index is real;
    // MODE 1 only needs one, so the same counter serves both.
    localparam logic [7:0] DONE_CAP = (MODE == 0) ? 8'(BUF_DELAY) : 8'd1;
    localparam bit         SKIP_EN  = (MODE == 1) && (BUF_LENTH >= 3);
    localparam bit         MODE0    = (MODE == 0);

    typedef enum logic {W_IDLE = 1'b0, W_BUSY = 1'b1} wstate_t;

    wstate_t    r_wstate;
    wstate_t    w_wstate_nxt;
    logic       w_complete;
    logic       w_abort;

    logic [7:0] r_wr_bufn;
    logic [7:0] r_rd_bufn;
    logic [7:0] r_last_done;
    logic [7:0] r_done_cnt;
    logic       r_rd_valid;
    logic       r_wr_abort;

    logic [8:0] w_wr9;
    logic [8:0] w_step1;
    logic [8:0] w_step2;
    logic [8:0] w_next;
    logic [8:0] w_rd_m0;
    logic       w_skip;
    logic       w_latch_en;
    logic [7:0] w_rd_latch;
    logic       w_valid_latch;

    // Write FSM state register
    always_ff @(posedge ui_clk) begin
        if (ui_rst) r_wstate <= W_IDLE;
        else        r_wstate <= w_wstate_nxt;
    end

    // Write FSM next state: a start always (re)opens a frame, an end closes it
    always_comb begin
        w_wstate_nxt = r_wstate;
        case (r_wstate)
            W_IDLE: if (bus.wr_fs_i) w_wstate_nxt = W_BUSY;
            W_BUSY: begin
                if (bus.wr_fe_i && !bus.wr_fs_i) w_wstate_nxt = W_IDLE;
                else                             w_wstate_nxt = W_BUSY;
            end
            default: w_wstate_nxt = W_IDLE;
        endcase
    end

    // Write FSM outputs: frame completion and overlapping-start abort
    always_comb begin
        w_complete = 1'b0;
        w_abort    = 1'b0;
        if (r_wstate == W_BUSY) begin
            w_complete = bus.wr_fe_i;
            w_abort    = bus.wr_fs_i && !bus.wr_fe_i;
        end
    end

    // Next write index, stepping over the buffer the reader holds in MODE 1
    always_comb begin
        w_wr9   = {1'b0, r_wr_bufn};
        w_step1 = (w_wr9 == LAST9) ? 9'd0 : w_wr9 + 9'd1;
        w_step2 = (w_step1 == LAST9) ? 9'd0 : w_step1 + 9'd1;
        w_skip  = SKIP_EN && r_rd_valid && (w_step1 == {1'b0, r_rd_bufn});
        w_next  = w_skip ? w_step2 : w_step1;
        w_rd_m0 = (w_wr9 < D9) ? L9 - D9 + w_wr9 : w_wr9 - D9;
    end

    // Read latch candidate, always from pre-update write-side values
    always_comb begin
        w_latch_en    = bus.rd_fs_i && (MODE0 || (r_done_cnt != 8'd0));
        w_rd_latch    = MODE0 ? 8'(w_rd_m0) : r_last_done;
        w_valid_latch = (r_done_cnt >= DONE_CAP);
    end

    // Write-side registers: index, newest completed buffer, completion count, abort pulse
    always_ff @(posedge ui_clk) begin
        if (ui_rst) begin
            r_wr_bufn   <= 8'd0;
            r_last_done <= 8'd0;
            r_done_cnt  <= 8'd0;
            r_wr_abort  <= 1'b0;
        end else begin
            r_wr_abort <= w_abort;
            if (w_complete) begin
                r_last_done <= r_wr_bufn;
                r_wr_bufn   <= 8'(w_next);
                if (r_done_cnt < DONE_CAP) r_done_cnt <= r_done_cnt + 8'd1;
            end
        end
    end

    // Read-side registers: change only on a qualifying read frame start
    always_ff @(posedge ui_clk) begin
        if (ui_rst) begin
            r_rd_bufn  <= RD_RST;
            r_rd_valid <= 1'b0;
        end else if (w_latch_en) begin
            r_rd_bufn  <= w_rd_latch;
            r_rd_valid <= w_valid_latch;
        end
    end

    assign bus.wr_bufn_o  = r_wr_bufn;
    assign bus.rd_bufn_o  = r_rd_bufn;
    assign bus.rd_valid_o = r_rd_valid;
    assign bus.wr_abort_o = r_wr_abort;

`ifdef UIVBUF_STAT_EN
    logic [15:0] r_drop_cnt;
    logic [15:0] r_rep_cnt;
    logic [1:0]  r_since;
    logic        r_latched;
    logic [1:0]  w_since_eff;
    logic        w_drop_inc;
    logic        w_rep_inc;

    // A read start closes the interval, so a completion in the same cycle opens the next one
    always_comb begin
        w_since_eff = bus.rd_fs_i ? 2'd0 : r_since;
        w_drop_inc  = w_complete && (w_skip || (w_since_eff != 2'd0));
        w_rep_inc   = w_latch_en && r_latched && (w_rd_latch == r_rd_bufn);
    end

    // Saturating drop/repeat counters
    always_ff @(posedge ui_clk) begin
        if (ui_rst) begin
            r_drop_cnt <= 16'd0;
            r_rep_cnt  <= 16'd0;
            r_since    <= 2'd0;
            r_latched  <= 1'b0;
        end else begin
            if (w_drop_inc && r_drop_cnt != 16'hFFFF) r_drop_cnt <= r_drop_cnt + 16'd1;
            if (w_rep_inc && r_rep_cnt != 16'hFFFF)   r_rep_cnt  <= r_rep_cnt + 16'd1;
            if (w_latch_en) r_latched <= 1'b1;
            if (w_complete) r_since <= (w_since_eff == 2'd0) ? 2'd1 : 2'd2;
            else            r_since <= w_since_eff;
        end
    end

    assign bus.drop_cnt_o = r_drop_cnt;
    assign bus.rep_cnt_o  = r_rep_cnt;
`endif
endmodule

// File: tb/tb_uivbuf_ctrl.sv
// tb/tb_uivbuf_ctrl.sv - three configurations checked against a modular-arithmetic model
`timescale 1ns/1ps
module tb_uivbuf_ctrl;
    logic ui_clk = 1'b0;
    logic ui_rst = 1'b1;
    always #5 ui_clk = ~ui_clk;

    logic [2:0] fs = '0;
    logic [2:0] fe = '0;
    logic [2:0] rfs = '0;
    logic [7:0] wrb [3];
    logic [7:0] rdb [3];
    logic       val [3];
    logic       abt [3];

    uivbuf_ctrl_if if0 ();
    uivbuf_ctrl_if if1 ();
    uivbuf_ctrl_if if2 ();

    uivbuf_ctrl #(.BUF_DELAY(1), .BUF_LENTH(3), .MODE(0)) u0 (.ui_clk(ui_clk), .ui_rst(ui_rst), .bus(if0.slave));
    uivbuf_ctrl #(.BUF_DELAY(2), .BUF_LENTH(4), .MODE(0)) u1 (.ui_clk(ui_clk), .ui_rst(ui_rst), .bus(if1.slave));
    uivbuf_ctrl #(.BUF_DELAY(1), .BUF_LENTH(3), .MODE(1)) u2 (.ui_clk(ui_clk), .ui_rst(ui_rst), .bus(if2.slave));

    assign if0.wr_fs_i = fs[0]; assign if0.wr_fe_i = fe[0]; assign if0.rd_fs_i = rfs[0];
    assign if1.wr_fs_i = fs[1]; assign if1.wr_fe_i = fe[1]; assign if1.rd_fs_i = rfs[1];
    assign if2.wr_fs_i = fs[2]; assign if2.wr_fe_i = fe[2]; assign if2.rd_fs_i = rfs[2];
    assign wrb[0] = if0.wr_bufn_o; assign rdb[0] = if0.rd_bufn_o; assign val[0] = if0.rd_valid_o; assign abt[0] = if0.wr_abort_o;
    assign wrb[1] = if1.wr_bufn_o; assign rdb[1] = if1.rd_bufn_o; assign val[1] = if1.rd_valid_o; assign abt[1] = if1.wr_abort_o;
    assign wrb[2] = if2.wr_bufn_o; assign rdb[2] = if2.rd_bufn_o; assign val[2] = if2.rd_valid_o; assign abt[2] = if2.wr_abort_o;

`ifdef UIVBUF_STAT_EN
    logic [15:0] drop [3];
    logic [15:0] rep  [3];
    assign drop[0] = if0.drop_cnt_o; assign rep[0] = if0.rep_cnt_o;
    assign drop[1] = if1.drop_cnt_o; assign rep[1] = if1.rep_cnt_o;
    assign drop[2] = if2.drop_cnt_o; assign rep[2] = if2.rep_cnt_o;
    int m_drop [3];
    int m_rep  [3];
    int m_since [3];
    bit m_latched [3];
`endif

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int plen(input int k);
        return (k == 1) ? 4 : 3;
    endfunction
    function automatic int pdel(input int k);
        return (k == 1) ? 2 : 1;
    endfunction
    function automatic int pmode(input int k);
        return (k == 2) ? 1 : 0;
    endfunction

    // Model: frame open flag, indices mod L, total completion count
    bit m_open  [3];
    int m_wr    [3];
    int m_rd    [3];
    int m_last  [3];
    int m_ncomp [3];
    bit m_valid [3];
    bit m_abort [3];
    bit model_live = 1'b0;

    always @(posedge ui_clk) begin
        int  L, D, M, nx, lat;
        bit  comp, skip;
        for (int k = 0; k < 3; k++) begin
            L = plen(k); D = pdel(k); M = pmode(k);
            if (ui_rst) begin
                m_open[k] = 0; m_wr[k] = 0; m_last[k] = 0; m_ncomp[k] = 0;
                m_rd[k] = (M == 0 && D > 0) ? L - D : 0;
                m_valid[k] = 0; m_abort[k] = 0;
`ifdef UIVBUF_STAT_EN
                m_drop[k] = 0; m_rep[k] = 0; m_since[k] = 0; m_latched[k] = 0;
`endif
            end else begin
                comp = m_open[k] && fe[k];
                m_abort[k] = m_open[k] && fs[k] && !fe[k];
                nx = (m_wr[k] + 1) % L;
                skip = (M == 1) && (L >= 3) && m_valid[k] && (nx == m_rd[k]);
                if (skip) nx = (nx + 1) % L;
                if (rfs[k]) begin
`ifdef UIVBUF_STAT_EN
                    m_since[k] = 0;
`endif
                    if (M == 0 || m_ncomp[k] > 0) begin
                        lat = (M == 0) ? (m_wr[k] + L - D) % L : m_last[k];
`ifdef UIVBUF_STAT_EN
                        if (m_latched[k] && lat == m_rd[k] && m_rep[k] < 65535) m_rep[k]++;
                        m_latched[k] = 1;
`endif
                        m_rd[k] = lat;
                        m_valid[k] = (M == 0) ? (m_ncomp[k] >= D) : 1'b1;
                    end
                end
                if (comp) begin
`ifdef UIVBUF_STAT_EN
                    if ((skip || m_since[k] > 0) && m_drop[k] < 65535) m_drop[k]++;
                    m_since[k]++;
`endif
                    m_last[k] = m_wr[k];
                    m_wr[k] = nx;
                    m_ncomp[k]++;
                end
                if (fs[k]) m_open[k] = 1;
                else if (fe[k]) m_open[k] = 0;
            end
        end
        model_live = 1'b1;
    end

    // Every-cycle comparison of all instances against the model
    always @(negedge ui_clk) begin
        if (model_live) begin
            for (int k = 0; k < 3; k++) begin
                chk($sformatf("model_wr_bufn[%0d]", k), wrb[k], m_wr[k]);
                chk($sformatf("model_rd_bufn[%0d]", k), rdb[k], m_rd[k]);
                chk($sformatf("model_rd_valid[%0d]", k), val[k], m_valid[k]);
                chk($sformatf("model_wr_abort[%0d]", k), abt[k], m_abort[k]);
`ifdef UIVBUF_STAT_EN
                chk($sformatf("model_drop[%0d]", k), drop[k], m_drop[k]);
                chk($sformatf("model_rep[%0d]", k), rep[k], m_rep[k]);
`endif
            end
        end
    end

    task automatic pulse(input int k, input bit a_fs, input bit a_fe, input bit a_rfs);
        fs[k] = a_fs; fe[k] = a_fe; rfs[k] = a_rfs;
        @(posedge ui_clk); #1;
        fs[k] = 1'b0; fe[k] = 1'b0; rfs[k] = 1'b0;
    endtask

    task automatic frame(input int k);
        pulse(k, 1, 0, 0);
        pulse(k, 0, 1, 0);
    endtask

    int ewr [4] = '{1, 2, 0, 1};
    int erd [4] = '{0, 1, 2, 0};

    initial begin
        repeat (2) @(posedge ui_clk);
        #1;
        chk("rst_wr0", wrb[0], 0);
        chk("rst_rd0", rdb[0], 2);
        chk("rst_rd1", rdb[1], 2);
        chk("rst_rd2", rdb[2], 0);
        chk("rst_val0", val[0], 0);
        chk("rst_abt0", abt[0], 0);
        ui_rst = 1'b0;
        pulse(0, 0, 0, 0);

        // MODE 0, L=3, D=1
        for (int i = 0; i < 4; i++) begin
            frame(0);
            chk($sformatf("m0_wr_%0d", i), wrb[0], ewr[i]);
            pulse(0, 0, 0, 1);
            chk($sformatf("m0_rd_%0d", i), rdb[0], erd[i]);
            chk($sformatf("m0_val_%0d", i), val[0], 1);
        end

        // MODE 0, L=4, D=2 wrap-around
        frame(1);
        pulse(1, 0, 0, 1);
        chk("m0b_rd_wrap", rdb[1], 3);
        chk("m0b_val_early", val[1], 0);
        frame(1);
        frame(1);
        chk("m0b_wr3", wrb[1], 3);
        pulse(1, 0, 0, 1);
        chk("m0b_rd_1", rdb[1], 1);
        chk("m0b_val", val[1], 1);

        // MODE 1 collision skip
        frame(2);
        pulse(2, 0, 0, 1);
        chk("m1_rd0", rdb[2], 0);
        chk("m1_val", val[2], 1);
        frame(2);
        chk("m1_wr2", wrb[2], 2);
        frame(2);
        chk("m1_skip_wr", wrb[2], 1);
`ifdef UIVBUF_STAT_EN
        chk("m1_drop", drop[2], 1);
`endif

        // Abort: second start while the frame is open
        pulse(2, 1, 0, 0);
        pulse(2, 1, 0, 0);
        chk("abort_hi", abt[2], 1);
        chk("abort_wr_hold", wrb[2], 1);
        pulse(2, 0, 0, 0);
        chk("abort_lo", abt[2], 0);
        pulse(2, 0, 1, 0);
        chk("abort_still_busy", wrb[2], 2);

        // MODE 1 same-cycle end and read start
        ui_rst = 1'b1;
        pulse(2, 0, 0, 0);
        ui_rst = 1'b0;
        pulse(2, 0, 0, 1);
        chk("m1_nodone_rd", rdb[2], 0);
        chk("m1_nodone_val", val[2], 0);
        frame(2);
        frame(2);
        pulse(2, 1, 0, 0);
        pulse(2, 0, 1, 1);
        chk("same_cyc_rd", rdb[2], 1);
        chk("same_cyc_wr", wrb[2], 0);
        chk("same_cyc_val", val[2], 1);

        // Reset mid-frame on the MODE 0 instance
        frame(0);
        frame(0);
        chk("mid_wr2", wrb[0], 2);
        pulse(0, 1, 0, 0);
        ui_rst = 1'b1;
        pulse(0, 0, 0, 0);
        ui_rst = 1'b0;
        chk("mid_rst_wr", wrb[0], 0);
        chk("mid_rst_rd", rdb[0], 2);
        chk("mid_rst_val", val[0], 0);
        chk("mid_rst_abt", abt[0], 0);
        pulse(0, 0, 1, 0);
        chk("mid_fe_ignored", wrb[0], 0);
        pulse(0, 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
